ad_nios_cascade_match_eval: RTL and testbench
=============================================

Name: ad_nios_cascade_match_eval

Overview:
- Time-multiplexed consumer of the LUT cascade-chain compare used in the Nios address/opcode decode.
- Takes a wide data word, a pattern and a care mask, then evaluates one SLICE_WIDTH-bit slice per clock. Each slice step does the AND-accumulate that a cascade chain does across LCELLs.
- Reports match/mismatch and the first failing slice with a start/busy/done handshake.
- Sits beside the Avalon decode logic. Wide compares are serialised through it to save logic elements.

Parameters:
- DATA_WIDTH, 32, compare word width; must be an integer multiple of SLICE_WIDTH.
- SLICE_WIDTH, 4, bits compared per cycle (one LCELL LUT input set).
- NUM_SLICES, DATA_WIDTH/SLICE_WIDTH, derived; not overridden.
- IDX_WIDTH, clog2(NUM_SLICES) (min 1), derived; width of mismatch_index.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request evaluation; sampled only in IDLE or DONE.
- abort  input  1  synchronous cancel; returns to IDLE with no done pulse.
- data  input  DATA_WIDTH  word under test; captured on accepted start.
- pattern  input  DATA_WIDTH  expected value; captured on accepted start.
- care_mask  input  DATA_WIDTH  1 = bit compared, 0 = don't-care; captured on accepted start.
- busy  output  1  high while in EVAL.
- done  output  1  one-cycle pulse: result valid.
- match  output  1  1 = all cared bits equal; held until the next accepted start.
- mismatch_index  output  IDX_WIDTH  first failing slice (0 = LSB slice); 0 when match=1; held with match.

Behaviour:
- Reset (async assert, sync release) forces state=IDLE and all outputs to 0: busy, done, match, mismatch_index. Internal capture registers and slice counter are cleared.
- Reset mid-EVAL abandons the evaluation immediately. No done pulse follows.
- States: IDLE, EVAL, DONE.
- IDLE: start=1 captures data, pattern and care_mask, sets acc=1 and slice_cnt=0, clears match and mismatch_index, then moves to EVAL.
- EVAL: busy=1. Each cycle computes slice_ok = ((data^pattern)&care_mask) restricted to bits [slice_cnt*SLICE_WIDTH +: SLICE_WIDTH] == 0.
  - On the first slice_ok=0, latch mismatch_index=slice_cnt and set acc=0. Later failures do not overwrite it.
  - When slice_cnt reaches NUM_SLICES-1, move to DONE. Otherwise increment slice_cnt.
- DONE: lasts exactly one cycle. done=1, match=acc, and mismatch_index is already final. The next state is IDLE, or EVAL if start=1 in this cycle (back-to-back accepted).
- Latency: start sampled at edge k gives busy high for edges k+1..k+NUM_SLICES and done high in the cycle after edge k+NUM_SLICES. Start to done is NUM_SLICES+1 cycles (9 at defaults).
- start while in EVAL is ignored; no queueing.
- data, pattern and care_mask changing after capture have no effect.
- abort has priority over start and over state advance. In any state it goes to IDLE, busy=0, done=0, and match/mismatch_index are cleared to 0.
- An all-zero care_mask always yields match=1.
- slice_cnt must not wrap within an evaluation. NUM_SLICES=1 is legal: one EVAL cycle.

Optional Feature:
- Macro: CASC_EARLY_EXIT_EN.
- Defined: on the first slice_ok=0, EVAL goes straight to DONE on that edge. Latency becomes mismatch_index+2 cycles for a mismatch; a match still takes NUM_SLICES+1.
- Undefined: every evaluation takes exactly NUM_SLICES+1 cycles, giving fixed latency. Remaining slices are scanned but cannot change the result.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles mid-EVAL with start pulsing -> busy=done=match=mismatch_index=0, no done pulse after release.
- Full match: data=32'hDEADBEEF, pattern=32'hDEADBEEF, care_mask=32'hFFFFFFFF, start 1 cycle -> busy 8 cycles, done pulse on cycle 9, match=1, mismatch_index=0.
- Masked mismatch: data=32'h1234_5678, pattern=32'h1234_0678, care_mask=32'hFFFF_0FFF -> match=1. With care_mask=32'hFFFF_FFFF -> match=0, mismatch_index=3.
  - Additionally with CASC_EARLY_EXIT_EN: done 5 cycles after start.
- Multiple failures: data=0, pattern=32'hF0000F00, mask all ones -> mismatch_index=2 (first failing slice, not 7); latency 9 without the macro.
- Handshake: start held high continuously -> new evaluation accepted in each DONE cycle, done pulses every 9 cycles. start pulses during EVAL are ignored (result reflects the originally captured data).
- Abort: assert abort on the 4th EVAL cycle together with start=1 -> next cycle IDLE, busy=0, no done, match=0. A later start evaluates normally.

Source files
------------

// File: rtl/ad_nios_cascade_match_eval.sv
// ad_nios_cascade_match_eval
//   Serialised wide masked compare. A start captures the word under test,
//   the expected pattern and the care mask; one SLICE_WIDTH-bit slice is
//   then checked per clock with a cascade-style AND-accumulate. The result
//   is match/mismatch plus the index of the first failing slice.
//
// Ports
//   clk            rising-edge system clock
//   reset_n        asynchronous active-low reset
//   start          request evaluation (accepted in IDLE or DONE only)
//   abort          synchronous cancel, back to IDLE, clears result, no done
//   data/pattern   word under test / expected value, captured on start
//   care_mask      1 = compare bit, 0 = don't care, captured on start
//   busy           high while slices are being scanned
//   done           one-cycle result-valid pulse
//   match          1 = all cared bits equal, held until next accepted start
//   mismatch_index first failing slice (0 = LSB slice), 0 on match
//
// Build option
//   CASC_EARLY_EXIT_EN  when defined, the scan stops on the first failing
//                       slice; otherwise latency is always NUM_SLICES+1.

module ad_nios_cascade_match_eval #(
    parameter  int DATA_WIDTH  = 32,
    parameter  int SLICE_WIDTH = 4,
    localparam int NUM_SLICES  = DATA_WIDTH / SLICE_WIDTH,
    localparam int IDX_WIDTH   = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [DATA_WIDTH-1:0] pattern,
    input  logic [DATA_WIDTH-1:0] care_mask,
    output logic                  busy,
    output logic                  done,
    output logic                  match,
    output logic [IDX_WIDTH-1:0]  mismatch_index
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_SLICE = IDX_WIDTH'(NUM_SLICES - 1);

    state_t                state_q, state_d;
    // Only the masked difference is needed afterwards, so the three
    // captured operands are folded into one register at start time.
    logic [DATA_WIDTH-1:0] diff_q, diff_d;
    logic [IDX_WIDTH-1:0]  slice_cnt_q, slice_cnt_d;
    logic                  acc_q, acc_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  match_q, match_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;

    logic [DATA_WIDTH-1:0] diff_shift;
    logic                  slice_ok;

    always_comb begin
        diff_shift = diff_q >> (32'(slice_cnt_q) * SLICE_WIDTH);
        slice_ok   = ~|diff_shift[SLICE_WIDTH-1:0];

        state_d     = state_q;
        diff_d      = diff_q;
        slice_cnt_d = slice_cnt_q;
        acc_d       = acc_q;
        match_d     = match_q;
        idx_d       = idx_q;

        if (abort) begin
            state_d = ST_IDLE;
            match_d = 1'b0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        diff_d      = (data ^ pattern) & care_mask;
                        acc_d       = 1'b1;
                        slice_cnt_d = '0;
                        match_d     = 1'b0;
                        idx_d       = '0;
                        state_d     = ST_EVAL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_EVAL: begin
                    // acc_q still set means no earlier slice failed, so this
                    // is the first failure and the index is latched.
                    if (!slice_ok && acc_q) begin
                        idx_d = slice_cnt_q;
                        acc_d = 1'b0;
                    end
`ifdef CASC_EARLY_EXIT_EN
                    if (!slice_ok || slice_cnt_q == LAST_SLICE) begin
`else
                    if (slice_cnt_q == LAST_SLICE) begin
`endif
                        state_d = ST_DONE;
                        match_d = acc_q & slice_ok;
                    end else begin
                        slice_cnt_d = slice_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_EVAL);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            diff_q      <= '0;
            slice_cnt_q <= '0;
            acc_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            match_q     <= 1'b0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            diff_q      <= diff_d;
            slice_cnt_q <= slice_cnt_d;
            acc_q       <= acc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            match_q     <= match_d;
            idx_q       <= idx_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign match          = match_q;
    assign mismatch_index = idx_q;

endmodule

// File: tb/tb_ad_nios_cascade_match_eval.sv
module tb_ad_nios_cascade_match_eval;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [31:0] data;
    logic [31:0] pattern;
    logic [31:0] care_mask;
    logic        busy;
    logic        done;
    logic        match;
    logic [2:0]  mismatch_index;

    int n_pass  = 0;
    int n_total = 0;

    ad_nios_cascade_match_eval dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .data           (data),
        .pattern        (pattern),
        .care_mask      (care_mask),
        .busy           (busy),
        .done           (done),
        .match          (match),
        .mismatch_index (mismatch_index)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called one cycle after the start edge; returns the cycle number in
    // which done is seen (1 = cycle right after the start edge).
    task automatic wait_done(output int cyc, output int busy_cyc);
        cyc      = 1;
        busy_cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) busy_cyc++;
            tick();
            cyc++;
        end
    endtask

    task automatic run_eval(input string tag, input logic [31:0] d, input logic [31:0] p,
                            input logic [31:0] m, input logic exp_match,
                            input logic [2:0] exp_idx, input int exp_lat);
        int cyc, bc;
        data = d; pattern = p; care_mask = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc, bc);
        chk({tag, "_lat"},   32'(cyc), 32'(exp_lat));
        chk({tag, "_busy"},  32'(bc), 32'(exp_lat - 1));
        chk({tag, "_match"}, 32'(match), 32'(exp_match));
        chk({tag, "_idx"},   32'(mismatch_index), 32'(exp_idx));
        tick();
        chk({tag, "_pulse"}, 32'(done), 32'd0);
        chk({tag, "_hold"},  32'(match), 32'(exp_match));
    endtask

    initial begin
        int cyc, bc, dcount;
        int lat_m3, lat_m2;
`ifdef CASC_EARLY_EXIT_EN
        lat_m3 = 5;
        lat_m2 = 4;
`else
        lat_m3 = 9;
        lat_m2 = 9;
`endif
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        data = '0; pattern = '0; care_mask = '0;
        tick(); tick();
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_idx",   32'(mismatch_index), 32'd0);
        reset_n = 1'b1;
        tick();

        run_eval("full",   32'hDEADBEEF, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b1, 3'd0, 9);
        run_eval("masked", 32'h12345678, 32'h12340678, 32'hFFFF0FFF, 1'b1, 3'd0, 9);
        run_eval("mis3",   32'h12345678, 32'h12340678, 32'hFFFFFFFF, 1'b0, 3'd3, lat_m3);
        run_eval("multi",  32'h00000000, 32'hF0000F00, 32'hFFFFFFFF, 1'b0, 3'd2, lat_m2);
        run_eval("zmask",  32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 3'd0, 9);
        run_eval("lsb",    32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, 3'd0, 
`ifdef CASC_EARLY_EXIT_EN
                 2);
`else
                 9);
`endif
        run_eval("msb",    32'h80000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 3'd7, 9);

        // abort while idle clears a held mismatch result
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle_idx", 32'(mismatch_index), 32'd0);

        // start pulses during EVAL with new operands are ignored
        data = 32'hCAFEF00D; pattern = 32'hCAFEF00D; care_mask = 32'hFFFFFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        data = 32'h0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 5;
        bc  = 0;
        while (done !== 1'b1 && cyc < 40) begin tick(); cyc++; end
        chk("ign_lat",   32'(cyc), 32'd9);
        chk("ign_match", 32'(match), 32'd1);
        tick(); tick();
        chk("ign_idle",  32'(busy), 32'd0);

        // start held high: back-to-back evaluations every 9 cycles
        data = 32'h12345678; pattern = 32'h12345678; care_mask = 32'hFFFFFFFF;
        start = 1'b1;
        tick();
        wait_done(cyc, bc);
        chk("b2b_lat1",   32'(cyc), 32'd9);
        chk("b2b_match1", 32'(match), 32'd1);
        tick();
        chk("b2b_busy",   32'(busy), 32'd1);
        wait_done(cyc, bc);
        chk("b2b_lat2",   32'(cyc), 32'd9);
        chk("b2b_match2", 32'(match), 32'd1);
        start = 1'b0;
        tick(); tick();

        // abort on 4th EVAL cycle together with start
        data = 32'h0; pattern = 32'hF0000F00; care_mask = 32'hFFFFFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("abort_pre_idx",  32'(mismatch_index), 32'd2);
        chk("abort_pre_busy", 32'(busy), 32'd1);
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("abort_busy",  32'(busy), 32'd0);
        chk("abort_done",  32'(done), 32'd0);
        chk("abort_match", 32'(match), 32'd0);
        chk("abort_idx",   32'(mismatch_index), 32'd0);
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) dcount++;
            tick();
        end
        chk("abort_nodone", 32'(dcount), 32'd0);
        run_eval("post_abort", 32'h00000000, 32'hF0000F00, 32'hFFFFFFFF, 1'b0, 3'd2, lat_m2);

        // reset mid-EVAL with start toggling
        data = 32'hDEADBEEF; pattern = 32'hDEADBEEF; care_mask = 32'hFFFFFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        reset_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            start = ~start;
            tick();
        end
        chk("mrst_done",  32'(done), 32'd0);
        chk("mrst_match", 32'(match), 32'd0);
        chk("mrst_idx",   32'(mismatch_index), 32'd0);
        start = 1'b0;
        reset_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1 || busy === 1'b1) dcount++;
            tick();
        end
        chk("mrst_quiet", 32'(dcount), 32'd0);
        run_eval("post_rst", 32'hDEADBEEF, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b1, 3'd0, 9);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
